// File: rtl/fp_alu_pkg.sv
// Shared types for the fixed-point ALU scheduler.
//   alu_op_t      : request opcode encoding (ADD/SUB/MUL/DIV)
//   sched_state_t : scheduler FSM states
package fp_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fp_alu_sched_rr_picker.sv
// Round-robin picker: combinational search for the first set valid bit
// starting at ptr and wrapping modulo N.
// Ports:
//   valid [N-1:0]  in   candidate requests
//   ptr   [PW-1:0] in   highest-priority index for this search
//   grant [N-1:0]  out  one-hot winner (all zero when nothing valid)
//   found          out  a winner exists
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);

  // One spare bit so ptr+i can exceed N before the wrap subtraction.
  logic [PW:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && valid[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_alu_sched.sv
// Fixed-point ALU scheduler: time-shares one add/sub/mul/div datapath among
// N_REQ requesters with round-robin arbitration and per-op latency.
// Ports:
//   clock, reset (async, active-high)
//   req_valid/req_op/req_a/req_b  per-requester request (sliced by index)
//   req_ready   one-hot combinational grant, only in IDLE
//   resp_valid  one-hot single-cycle result pulse to the owner
//   resp_data   registered result, held outside DONE
//   busy        high in EXEC and DONE
//   op_count    completed-operation counter (only with FP_ALU_SCHED_STATS_EN)
//
// state | meaning
// IDLE  | arbitrate; accept winner, latch op/operands/id
// EXEC  | count down op latency; register result when cnt hits 0
// DONE  | pulse resp_valid to the owner for one cycle
module fp_alu_sched
  import fp_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int Q       = 16,
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
`ifdef FP_ALU_SCHED_STATS_EN
  output logic [31:0]            op_count,
`endif
  output logic                   busy
);

  localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  sched_state_t     state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    id_q, id_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] grant;
  logic             found;
  logic [PW-1:0]    gid;
  alu_op_t          op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [CW-1:0]    lat_m1;

  rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .found (found)
  );

  // Mux the winner's request fields from the one-hot grant.
  always_comb begin
    gid    = '0;
    op_sel = OP_ADD;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gid    = PW'(i);
        op_sel = alu_op_t'(req_op[2*i +: 2]);
        a_sel  = req_a[WIDTH*i +: WIDTH];
        b_sel  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    case (op_sel)
      OP_MUL:  lat_m1 = CW'(MUL_LAT - 1);
      OP_DIV:  lat_m1 = CW'(DIV_LAT - 1);
      default: lat_m1 = '0;
    endcase
  end

  // Datapath works on magnitudes; sign is reapplied afterwards so both MUL
  // and DIV truncate toward zero. These wide paths are multicycle.
  logic [WIDTH-1:0]     mag_a, mag_b, mag_res, alu_res;
  logic                 neg;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH+Q-1:0]   quot, divisor;

  always_comb begin
    mag_a   = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b   = b_q[WIDTH-1] ? -b_q : b_q;
    neg     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod    = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
    // Divisor forced nonzero so the unused quotient never goes X on b==0.
    divisor = (mag_b == '0) ? (WIDTH+Q)'(1) : (WIDTH+Q)'(mag_b);
    quot    = ((WIDTH+Q)'(mag_a) << Q) / divisor;
    mag_res = '0;
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
      OP_MUL: begin
        mag_res = WIDTH'(prod >> Q);
        alu_res = neg ? -mag_res : mag_res;
      end
      default: begin
        if (b_q == '0) begin
          alu_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          mag_res = WIDTH'(quot);
          alu_res = neg ? -mag_res : mag_res;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = gid;
          ptr_d   = (gid == PW'(N_REQ - 1)) ? '0 : gid + 1'b1;
          cnt_d   = lat_m1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_res;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? grant : '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = (state_q == DONE) && (id_q == PW'(i));
    end
  end

  assign resp_data = res_q;
  assign busy      = (state_q != IDLE);

`ifdef FP_ALU_SCHED_STATS_EN
  logic [31:0] op_count_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                op_count_q <= '0;
    else if (state_q == DONE) op_count_q <= op_count_q + 32'd1;
  end
  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_fp_alu_sched.sv
// Scoreboard bench for fp_alu_sched: drivers push expected responses at
// grant time, a negedge monitor pops and compares on every resp_valid.
module tb_fp_alu_sched;
  localparam int W = 32;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_data;
  logic           busy;
`ifdef FP_ALU_SCHED_STATS_EN
  logic [31:0]    op_count;
`endif

  fp_alu_sched #(.WIDTH(32), .Q(16), .N_REQ(4), .MUL_LAT(2), .DIV_LAT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
`ifdef FP_ALU_SCHED_STATS_EN
    .op_count   (op_count),
`endif
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc++;

  function automatic int lat(input logic [1:0] op);
    case (op)
      2'd2:    return 2;
      2'd3:    return 8;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: response checking and req_ready one-hot property.
  always @(negedge clock) begin
    if (!reset) begin
      if (req_ready != '0) begin
        tests++;
        if (!$onehot(req_ready)) begin
          fails++;
          $display("FAIL ready_onehot: got %b expected one-hot", req_ready);
        end
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got resp_valid=%b data=0x%08h expected none", resp_valid, resp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_valid_id", 32'(resp_valid), 32'(1) << e.id);
          check("resp_data", resp_data, e.data);
          check("resp_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic drive(input int id, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_d, input bit chk);
    bit got;
    got = 1'b0;
    @(posedge clock); #1;
    req_valid[id]        = 1'b1;
    req_op[2*id +: 2]    = op;
    req_a[W*id +: W]     = a;
    req_b[W*id +: W]     = b;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      if (req_ready[id]) begin
        got = 1'b1;
        glog.push_back(id);
        if (chk) sb.push_back('{id, exp_d, cyc + lat(op) + 1});
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL grant_timeout: requester %0d got no grant, expected grant within 200 cycles", id);
    end
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_glog(input string name, input int e0, input int e1, input int e2,
                            input int e3, input int e4, input int n);
    int exp_a[5];
    exp_a = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++)
      check(name, 32'(glog[i]), 32'(exp_a[i]));
    glog.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready_idle", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Contention: all four valid from reset, requester 0 comes back once more.
    fork
      begin
        drive(0, 2'd0, 32'h1, 32'h2, 32'h3, 1'b1);
        drive(0, 2'd0, 32'h5, 32'h6, 32'hB, 1'b1);
      end
      drive(1, 2'd0, 32'h10, 32'h20, 32'h30, 1'b1);
      drive(2, 2'd0, 32'h100, 32'h200, 32'h300, 1'b1);
      drive(3, 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    join
    drain();
    check_glog("grant_order_rr", 0, 1, 2, 3, 0, 5);

    // Directed arithmetic on a single requester.
    drive(0, 2'd0, 32'h0001_8000, 32'h0002_0000, 32'h0003_8000, 1'b1);
    drive(0, 2'd1, 32'h0001_0000, 32'h0003_0000, 32'hFFFE_0000, 1'b1);
    drive(0, 2'd2, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b1);
    drive(0, 2'd3, 32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b1);
    drive(0, 2'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b1);
    drive(0, 2'd3, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
    drive(0, 2'd3, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
    drive(0, 2'd2, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_C000, 1'b1);
    drain();
    glog.delete();
    repeat (3) @(negedge clock);
    check("resp_data_hold", resp_data, 32'hFFFF_C000);

    // Pointer wrap: grant 2 leaves ptr at 3, then 3 wins over 1.
    drive(2, 2'd0, 32'h7, 32'h8, 32'hF, 1'b1);
    fork
      drive(1, 2'd1, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1);
      drive(3, 2'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    join
    drain();
    check_glog("grant_order_wrap", 2, 3, 1, 0, 0, 3);

    // Reset in the middle of a DIV: no response, new request granted at once.
    drive(0, 2'd3, 32'h0001_0000, 32'h0003_0000, 32'h0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset          = 1'b0;
    req_valid[1]   = 1'b1;
    req_op[3:2]    = 2'd0;
    req_a[63:32]   = 32'h1000;
    req_b[63:32]   = 32'h1000;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0010);
    sb.push_back('{1, 32'h2000, cyc + 2});
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    repeat (20) @(posedge clock);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
